// File: rtl/keccak_block_padder.sv
// Keccak front end: packs 64-bit message words into one rate-sized block, applies
// SHA-3/SHAKE multi-rate padding and offers the block to the permutation stage.
module keccak_block_padder #(
    parameter int MAX_WORDS = 21,
    parameter int CNT_W     = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [63:0]            in,
    input  logic                   in_valid,
    input  logic                   is_last,
    input  logic [2:0]             byte_num,
    output logic                   in_ready,
    output logic [MAX_WORDS*64-1:0] out,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready
);

    typedef enum logic {ACCEPT, FULL} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             out_last_reg, out_last_next;
    logic [CNT_W-1:0] rate_m1;
    logic [63:0]      padded_word;
    logic             accept_fire;
    logic             out_fire;

    // Index of the final word of the block for the selected rate.
    function automatic logic [CNT_W-1:0] rate_last(input logic [1:0] m);
        logic [CNT_W-1:0] r;
        case (m)
            2'b00:   r = CNT_W'(20);
            2'b01:   r = CNT_W'(16);
            2'b10:   r = CNT_W'(16);
            default: r = CNT_W'(8);
        endcase
        return r;
    endfunction

    // Keep the valid leading bytes, put the domain byte right after them, clear the rest.
    function automatic logic [63:0] padder1(input logic [63:0] w, input logic [2:0] n,
                                            input logic [1:0] m);
        logic [63:0] r;
        logic [7:0]  dom;
        int          nb;
        r   = '0;
        dom = m[1] ? 8'h06 : 8'h1f;
        nb  = int'(n);
        for (int j = 0; j < 8; j++) begin
            if (j < nb)
                r[63-8*j -: 8] = w[63-8*j -: 8];
            else if (j == nb)
                r[63-8*j -: 8] = dom;
        end
        return r;
    endfunction

    assign rate_m1     = rate_last(mode);
    assign padded_word = padder1(in, byte_num, mode);
    assign accept_fire = (state_reg == ACCEPT) && in_valid;
    assign out_fire    = (state_reg == FULL) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ACCEPT;
            cnt_reg      <= '0;
            out_last_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            out_last_reg <= out_last_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        out_last_next = out_last_reg;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        case (state_reg)
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_last) begin
                        cnt_next      = '0;
                        out_last_next = 1'b1;
                        state_next    = FULL;
                    end else if (cnt_reg >= rate_m1) begin
                        cnt_next      = '0;
                        out_last_next = 1'b0;
                        state_next    = FULL;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            FULL: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = ACCEPT;
            end
            default: state_next = ACCEPT;
        endcase
    end

    assign out_last = out_last_reg;

    // One register per block word; the 0x80 OR is applied after the data write so
    // that a last word landing in the final slot gets both the domain byte and the bit.
    for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_word
        logic [63:0] word_reg, word_next;

        always_comb begin
            word_next = word_reg;
            if (out_fire) begin
                word_next = '0;
            end else if (accept_fire) begin
                if (cnt_reg == CNT_W'(gi))
                    word_next = is_last ? padded_word : in;
                if (is_last && (rate_m1 == CNT_W'(gi)))
                    word_next[7:0] = word_next[7:0] | 8'h80;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                word_reg <= '0;
            else
                word_reg <= word_next;
        end

        assign out[MAX_WORDS*64-1-64*gi -: 64] = word_reg;
    end

endmodule

// File: tb/tb_keccak_block_padder.sv
// Self-checking bench for keccak_block_padder: directed corner cases plus random
// messages compared against a byte-level SHA-3 padding model.
module tb_keccak_block_padder;

    logic          clk;
    logic          rst_n;
    logic [1:0]    mode;
    logic [63:0]   in_data;
    logic          in_valid;
    logic          is_last;
    logic [2:0]    byte_num;
    logic          in_ready;
    logic [1343:0] out_blk;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;

    int tests = 0;
    int fails = 0;

    logic [7:0]    msg [0:511];
    logic [7:0]    pad [0:1023];
    logic [1343:0] exp_q[$];
    bit            exp_last_q[$];

    keccak_block_padder dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in(in_data), .in_valid(in_valid),
        .is_last(is_last), .byte_num(byte_num), .in_ready(in_ready), .out(out_blk),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int rate_words(input logic [1:0] m);
        return (m == 2'b00) ? 21 : ((m == 2'b11) ? 9 : 17);
    endfunction

    // Pad msg[0..n-1] as a byte string and cut it into rate-sized blocks.
    task automatic build_expected(input logic [1:0] m, input int n);
        int rb, len, nblk;
        logic [1343:0] blk;
        rb   = rate_words(m) * 8;
        len  = ((n + 1 + rb - 1) / rb) * rb;
        nblk = len / rb;
        for (int i = 0; i < len; i++) pad[i] = (i < n) ? msg[i] : 8'h00;
        pad[n]     = m[1] ? 8'h06 : 8'h1f;
        pad[len-1] = pad[len-1] | 8'h80;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int k = 0; k < rate_words(m); k++)
                for (int j = 0; j < 8; j++)
                    blk[1343-64*k-8*j -: 8] = pad[b*rb + 8*k + j];
            exp_q.push_back(blk);
            exp_last_q.push_back(b == nblk - 1);
        end
    endtask

    function automatic logic [63:0] word_of(input int i, input int n);
        logic [63:0] w;
        for (int j = 0; j < 8; j++)
            w[63-8*j -: 8] = (8*i + j < n) ? msg[8*i + j] : 8'($urandom);
        return w;
    endfunction

    task automatic check_block(input string tag);
        logic [1343:0] e;
        bit el;
        if (exp_q.size() == 0) begin
            chk({tag, " unexpected block"}, 64'(out_valid), 64'd0);
        end else begin
            e  = exp_q.pop_front();
            el = exp_last_q.pop_front();
            chk({tag, " last"}, 64'(out_last), 64'(el));
            for (int k = 0; k < 21; k++)
                chk($sformatf("%s w%0d", tag, k), out_blk[1343-64*k -: 64], e[1343-64*k -: 64]);
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        is_last   = 1'b0;
    endtask

    // Stream one message of n bytes; rnd adds random stalls, hold freezes each block 10 cycles.
    task automatic send_message(input logic [1:0] m, input int n, input bit rnd, input bit hold,
                                input string tag);
        int nw, idx, cycles, hold_cnt;
        bit iv, orr;
        logic [1343:0] held;
        logic [63:0] cur;
        for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
        if (n == 167) for (int j = 0; j < 7; j++) msg[160+j] = 8'(8'h11 * (j + 1));
        build_expected(m, n);
        nw = n / 8 + 1;
        idx = 0; cycles = 0; hold_cnt = 0; held = '0;
        cur = word_of(0, n);
        while ((idx < nw || exp_q.size() > 0) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (out_valid) begin
                if (hold_cnt == 0) held = out_blk;
                else begin
                    chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
                    chk({tag, " hold stable"}, 64'(out_blk == held), 64'd1);
                end
            end else hold_cnt = 0;
            iv = (idx < nw) && (hold || !rnd || ($urandom_range(0, 2) != 0));
            if (hold && out_valid && hold_cnt < 10) begin
                orr = 1'b0;
                hold_cnt++;
            end else begin
                orr = !rnd || ($urandom_range(0, 1) != 0);
            end
            mode      = m;
            in_valid  = iv;
            in_data   = cur;
            is_last   = (idx == nw - 1);
            byte_num  = 3'(n % 8);
            out_ready = orr;
            if (out_valid && orr) check_block(tag);
            if (iv && in_ready) begin
                idx++;
                if (idx < nw) cur = word_of(idx, n);
            end
        end
        chk({tag, " timeout"}, 64'(cycles < 3000), 64'd1);
        go_idle();
        @(negedge clk);
        chk({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
        exp_q.delete();
        exp_last_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b00; in_data = '0; in_valid = 1'b0;
        is_last = 1'b0; byte_num = '0; out_ready = 1'b0;
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_last", 64'(out_last), 64'd0);
        for (int k = 0; k < 21; k++) chk($sformatf("rst w%0d", k), out_blk[1343-64*k -: 64], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // SHA3-512 empty message: byte_num=0 so the data word is ignored.
        @(negedge clk);
        mode = 2'b11; in_data = 64'hdeadbeefcafef00d; in_valid = 1'b1; is_last = 1'b1; byte_num = 3'd0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("sha512 out_valid", 64'(out_valid), 64'd1);
        chk("sha512 out_last", 64'(out_last), 64'd1);
        for (int k = 0; k < 21; k++)
            chk($sformatf("sha512 w%0d", k), out_blk[1343-64*k -: 64],
                (k == 0) ? 64'h0600000000000000 : ((k == 8) ? 64'h80 : 64'h0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("sha512 consumed", 64'(out_valid), 64'd0);
        chk("sha512 in_ready back", 64'(in_ready), 64'd1);

        send_message(2'b00, 167, 1'b0, 1'b0, "shake128 bn7");
        send_message(2'b01, 136, 1'b0, 1'b0, "shake256 exact");
        send_message(2'b11, 80, 1'b0, 1'b1, "hold");

        for (int t = 0; t < 8; t++)
            send_message((t % 2 == 0) ? 2'b00 : 2'b11, $urandom_range(0, 260), 1'b1, 1'b0,
                         $sformatf("rand%0d", t));
        send_message(2'b10, $urandom_range(0, 200), 1'b1, 1'b0, "rand sha256");

        // Reset with five words already buffered.
        mode = 2'b00; is_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 64'($urandom) << 32 | 64'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst msg out_valid", 64'(out_valid), 64'd0);
        chk("rst msg in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send_message(2'b00, 50, 1'b0, 1'b0, "after rst msg");

        // Reset while a full block waits for the permutation.
        mode = 2'b11; is_last = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 64'($urandom) << 32 | 64'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre rst full", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst full out_valid", 64'(out_valid), 64'd0);
        chk("rst full in_ready", 64'(in_ready), 64'd1);
        chk("rst full w0", out_blk[1343 -: 64], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_message(2'b11, 30, 1'b1, 1'b0, "after rst full");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
